// File: rtl/mem_responder_if.sv
// Request/completion bundle between the scheduler path and mem_responder.
// master drives requests and observes completions; slave is the responder.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned IDX_W  = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_type;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_data;
  logic [IDX_W-1:0]  req_index;
  logic              request_done_valid;
  logic              the_type;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  index;

  modport master (
    output req_valid, req_type, req_address, req_data, req_index,
    input  req_ready, request_done_valid, the_type, data_in, index
  );

  modport slave (
    input  req_valid, req_type, req_address, req_data, req_index,
    output req_ready, request_done_valid, the_type, data_in, index
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: executes requests against a word memory at accept,
// delays them by type-specific latency and streams completions in order.
module mem_responder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 26,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned MEM_AW   = 6,
  parameter int unsigned RD_LAT   = 4,
  parameter int unsigned WR_LAT   = 2,
  parameter int unsigned CQ_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  localparam int unsigned MEM_WORDS = 1 << MEM_AW;
  localparam int unsigned PTR_W     = $clog2(CQ_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic              typ;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } cpl_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [RD_LAT-1:0] rd_vld;
  logic [WR_LAT-1:0] wr_vld;
  cpl_t              rd_pl [RD_LAT];
  cpl_t              wr_pl [WR_LAT];
  cpl_t              q_mem [CQ_DEPTH];
  logic [PTR_W-1:0]  q_rd;
  logic [PTR_W-1:0]  q_wr;
  logic [CNT_W-1:0]  q_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              done_q;
  cpl_t              out_q;

  logic [MEM_AW-1:0] addr_c;
  logic              ready_c;
  logic              accept_c;
  logic              q_pop_c;
  logic              rd_exit_vld_c;
  logic              wr_exit_vld_c;
  cpl_t              rd_exit_c;
  cpl_t              wr_exit_c;
  logic              out_vld_c;
  cpl_t              out_pl_c;
  logic [1:0]        push_cnt_c;
  cpl_t              push_a_c;
  cpl_t              push_b_c;
  logic              unused_addr_hi_c;

  assign addr_c           = bus.req_address[MEM_AW-1:0];
  assign unused_addr_hi_c = ^bus.req_address[ADDR_W-1:MEM_AW];
  assign ready_c          = out_cnt < CNT_W'(CQ_DEPTH);
  assign accept_c         = bus.req_valid && ready_c;
  assign q_pop_c          = q_cnt != '0;
  assign rd_exit_vld_c    = rd_vld[RD_LAT-1];
  assign wr_exit_vld_c    = wr_vld[WR_LAT-1];
  assign rd_exit_c        = rd_pl[RD_LAT-1];
  assign wr_exit_c        = wr_pl[WR_LAT-1];

  // Word memory; writes land at the accept edge so effects follow accept order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
    end else if (accept_c && bus.req_type) begin
      mem[addr_c] <= bus.req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= '0;
      wr_vld <= '0;
    end else begin
      rd_vld <= RD_LAT'({rd_vld, accept_c && !bus.req_type});
      wr_vld <= WR_LAT'({wr_vld, accept_c && bus.req_type});
    end
  end

  // Payload stages follow their valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    rd_pl[0] <= '{typ: 1'b0, data: mem[addr_c], idx: bus.req_index};
    wr_pl[0] <= '{typ: 1'b1, data: bus.req_data, idx: bus.req_index};
    for (int i = 1; i < int'(RD_LAT); i++) rd_pl[i] <= rd_pl[i-1];
    for (int i = 1; i < int'(WR_LAT); i++) wr_pl[i] <= wr_pl[i-1];
  end

  // Ordering: queued entries first, then read exit, then write exit; the
  // first candidate goes straight to the output, the rest are queued.
  always_comb begin
    out_vld_c  = 1'b0;
    out_pl_c   = '0;
    push_cnt_c = 2'd0;
    push_a_c   = '0;
    push_b_c   = '0;
    if (q_pop_c) begin
      out_vld_c = 1'b1;
      out_pl_c  = q_mem[q_rd];
      if (rd_exit_vld_c) begin
        push_a_c   = rd_exit_c;
        push_cnt_c = 2'd1;
        if (wr_exit_vld_c) begin
          push_b_c   = wr_exit_c;
          push_cnt_c = 2'd2;
        end
      end else if (wr_exit_vld_c) begin
        push_a_c   = wr_exit_c;
        push_cnt_c = 2'd1;
      end
    end else if (rd_exit_vld_c) begin
      out_vld_c = 1'b1;
      out_pl_c  = rd_exit_c;
      if (wr_exit_vld_c) begin
        push_a_c   = wr_exit_c;
        push_cnt_c = 2'd1;
      end
    end else if (wr_exit_vld_c) begin
      out_vld_c = 1'b1;
      out_pl_c  = wr_exit_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      q_rd  <= q_rd + PTR_W'(q_pop_c);
      q_wr  <= q_wr + PTR_W'(push_cnt_c);
      q_cnt <= q_cnt + CNT_W'(push_cnt_c) - CNT_W'(q_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt_c != 2'd0) q_mem[q_wr] <= push_a_c;
    if (push_cnt_c == 2'd2) q_mem[q_wr + PTR_W'(1)] <= push_b_c;
  end

  // Outstanding requests bound queue occupancy, so it can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      out_cnt <= out_cnt + CNT_W'(accept_c) - CNT_W'(out_vld_c);
      done_q  <= out_vld_c;
      out_q   <= out_pl_c;
    end
  end

  assign bus.req_ready          = ready_c;
  assign bus.request_done_valid = done_q;
  assign bus.the_type           = out_q.typ;
  assign bus.data_in            = out_q.data;
  assign bus.index              = out_q.idx;
endmodule
